ov7670_pixel_filter: RTL and testbench
======================================

Name: ov7670_pixel_filter

Overview:
- Pixel-stream filter stage directly downstream of the OV7670 capture/memory write controller and upstream of the frame-buffer write port, in the pclk domain.
- Consumes the capture stage's write strobe, 17-bit address and 16-bit RGB565 word, applies a frame-stable selectable lens filter, and re-emits an identically timed write transaction 2 cycles later.
- Also reports the per-frame written-pixel count and a frame-done pulse.

Parameters:
- THRESH, 8'd128, luma threshold for binary mode (Y >= THRESH gives white).
- ADDR_W, 17, address width (320*240 frame buffer).

Ports:
- pclk  in  1  camera pixel clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- vsync  in  1  camera vsync, raw from sensor, already in pclk domain
- mode  in  2  filter select: 0 pass, 1 gray, 2 invert, 3 binary
- in_we  in  1  write strobe from capture stage
- in_addr  in  ADDR_W  write address from capture stage
- in_data  in  16  RGB565 pixel {R5,G6,B5}
- out_we  out  1  write strobe to frame buffer
- out_addr  out  ADDR_W  write address to frame buffer
- out_data  out  16  filtered RGB565 pixel
- active_mode  out  2  mode in force for the current frame
- frame_done  out  1  single-cycle pulse at frame close
- pixel_count  out  ADDR_W  writes counted in last closed frame

Behaviour:
- Reset (async assert, sync-free): all pipeline registers 0, out_we=0, out_addr=0, out_data=0, active_mode=0, frame_done=0, pixel_count=0, running counter=0, vsync_d=0. Reset mid-frame discards in-flight pixels; no out_we until new in_we arrives after release.
- Clock and reset usage:
  - The block has one clock, pclk.
  - reset_n is asynchronous and active-low.
- Pipeline: fixed latency 2 cycles. in_we/in_addr sampled at cycle N appear on out_we/out_addr at N+2, every cycle, no stalls, no backpressure.
- in_data is captured when in_we=1. Registers hold when in_we=0; out_data holds its last value while out_we=0.
- Stage 1:
  - Expand R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
  - Compute sum = R8*77 + G8*150 + B8*29, unsigned 16-bit, no overflow since max = 255*256.
  - Y = sum[15:8].
  - Carry the original pixel alongside.
- Stage 2 format, per active_mode:
  - 0: original pixel unchanged.
  - 1: {Y[7:3], Y[7:2], Y[7:3]}.
  - 2: ~pixel (bitwise).
  - 3: (Y >= THRESH) ? 16'hFFFF : 16'h0000.
- Mode latching:
  - vsync_d is a registered copy of vsync; a rising edge is (vsync & ~vsync_d).
  - active_mode <= mode only on a rising edge. A mode change mid-frame has no effect until the next edge.
  - Pixels still in the pipeline at the edge use the new mode from the following cycle. This is acceptable because the capture stage writes nothing while vsync is high.
- Frame accounting:
  - The running counter increments on each out_we=1, saturating at all-ones.
  - On a rising edge: pixel_count <= running count (including an out_we in that same cycle), frame_done=1 for exactly one cycle, running counter <= 0.
  - frame_done pulses even when the count is 0 (sensor produced an empty frame).
- Addresses pass through unmodified; no wrap handling here, since wrap belongs to the producer.

Test Plan:
- Reset: hold reset_n=0 with in_we toggling -> all outputs 0; release, drive in_we=1, in_addr=5, in_data=16'hF800 at cycle N -> out_we=1, out_addr=5, out_data=16'hF800 at N+2 with mode 0.
- Gray: after a vsync edge with mode=1, pixels 16'hFFFF, 16'h0000 and 16'hF800 -> out_data 16'hFFFF, 16'h0000 and 16'h4A69 (Y=76).
- Invert and binary: mode=2 with 16'h1234 -> 16'hEDCB. Mode=3, THRESH=128 with 16'h07E0 (Y=149) -> 16'hFFFF; with 16'h001F (Y=28) -> 16'h0000.
- Mode stability: switch mode 0->2 mid-frame -> output stays passthrough until the next vsync rise, then inverted; active_mode changes 1 cycle after the edge.
- Frame count: 76800 writes, then vsync rise -> frame_done single pulse, pixel_count=76800, running counter cleared. A second vsync with no writes -> pulse again with pixel_count=0.
- Async reset mid-stream: drop reset_n between two in_we pulses -> outputs 0 immediately without a clock edge; the pending pixel is never emitted.

Source files
------------

// File: rtl/ov7670_pixel_filter.sv
// OV7670 pixel-stream lens filter: two-stage pipeline between the capture write
// port and the frame buffer, with frame-latched mode and per-frame write counting.
module ov7670_pixel_filter #(
  parameter logic [7:0] THRESH = 8'd128,
  parameter int         ADDR_W = 17
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              vsync,
  input  logic [1:0]        mode,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [15:0]       in_data,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       out_data,
  output logic [1:0]        active_mode,
  output logic              frame_done,
  output logic [ADDR_W-1:0] pixel_count
);

  localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};

  // BT.601-style luma from RGB565, channels widened to 8 bits by bit replication
  function automatic logic [7:0] luma(input logic [15:0] px);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    r8  = {px[15:11], px[15:13]};
    g8  = {px[10:5], px[10:9]};
    b8  = {px[4:0], px[4:2]};
    sum = (16'(r8) * 16'd77) + (16'(g8) * 16'd150) + (16'(b8) * 16'd29);
    return sum[15:8];
  endfunction

  logic              s1_we_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [15:0]       s1_pix_q;
  logic [7:0]        s1_y_q;

  logic              out_we_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [15:0]       out_data_q;
  logic [15:0]       fmt_d;

  logic              vsync_q;
  logic              rise_s;
  logic [1:0]        active_mode_q;
  logic              frame_done_q;
  logic [ADDR_W-1:0] pixel_count_q;
  logic [ADDR_W-1:0] run_cnt_q;
  logic [ADDR_W-1:0] run_cnt_d;

  // Stage 1: strobe/address every cycle; pixel and luma only on a write
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      s1_we_q   <= 1'b0;
      s1_addr_q <= '0;
      s1_pix_q  <= 16'h0000;
      s1_y_q    <= 8'h00;
    end else begin
      s1_we_q   <= in_we;
      s1_addr_q <= in_addr;
      if (in_we) begin
        s1_pix_q <= in_data;
        s1_y_q   <= luma(in_data);
      end else begin
        s1_pix_q <= s1_pix_q;
        s1_y_q   <= s1_y_q;
      end
    end
  end

  // Stage 2 formatting selected by the mode latched for this frame
  always_comb begin
    fmt_d = s1_pix_q;
    case (active_mode_q)
      2'd0:    fmt_d = s1_pix_q;
      2'd1:    fmt_d = {s1_y_q[7:3], s1_y_q[7:2], s1_y_q[7:3]};
      2'd2:    fmt_d = ~s1_pix_q;
      2'd3:    fmt_d = (s1_y_q >= THRESH) ? 16'hFFFF : 16'h0000;
      default: fmt_d = s1_pix_q;
    endcase
  end

  // Stage 2 output registers; data holds while no write is emitted
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= 16'h0000;
    end else begin
      out_we_q   <= s1_we_q;
      out_addr_q <= s1_addr_q;
      if (s1_we_q) begin
        out_data_q <= fmt_d;
      end else begin
        out_data_q <= out_data_q;
      end
    end
  end

  assign rise_s = vsync & ~vsync_q;

  // Running count including any write emitted this cycle, saturating
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (out_we_q && (run_cnt_q != CNT_MAX)) begin
      run_cnt_d = run_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      run_cnt_d = run_cnt_q;
    end
  end

  // Frame close on vsync rise: latch mode, publish count, pulse done
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q       <= 1'b0;
      active_mode_q <= 2'd0;
      frame_done_q  <= 1'b0;
      pixel_count_q <= '0;
      run_cnt_q     <= '0;
    end else begin
      vsync_q      <= vsync;
      frame_done_q <= rise_s;
      if (rise_s) begin
        active_mode_q <= mode;
        pixel_count_q <= run_cnt_d;
        run_cnt_q     <= '0;
      end else begin
        active_mode_q <= active_mode_q;
        pixel_count_q <= pixel_count_q;
        run_cnt_q     <= run_cnt_d;
      end
    end
  end

  assign out_we      = out_we_q;
  assign out_addr    = out_addr_q;
  assign out_data    = out_data_q;
  assign active_mode = active_mode_q;
  assign frame_done  = frame_done_q;
  assign pixel_count = pixel_count_q;

endmodule

// File: tb/tb_ov7670_pixel_filter.sv
// Scoreboard bench for ov7670_pixel_filter: directed pixels with hand-computed results.
module tb_ov7670_pixel_filter;

  logic        pclk = 1'b0;
  logic        reset_n;
  logic        vsync;
  logic [1:0]  mode;
  logic        in_we;
  logic [16:0] in_addr;
  logic [15:0] in_data;
  logic        out_we;
  logic [16:0] out_addr;
  logic [15:0] out_data;
  logic [1:0]  active_mode;
  logic        frame_done;
  logic [16:0] pixel_count;

  typedef struct packed {
    logic [16:0] addr;
    logic [15:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  ov7670_pixel_filter dut (
    .pclk(pclk), .reset_n(reset_n), .vsync(vsync), .mode(mode),
    .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
    .active_mode(active_mode), .frame_done(frame_done), .pixel_count(pixel_count)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every emitted write must match the oldest expectation, at the right cycle
  always @(negedge pclk) begin
    exp_t e;
    if (out_we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_we: got addr=%0h data=%0h expected no write", out_addr, out_data);
      end else begin
        e = sb.pop_front();
        check("out_addr", 32'(out_addr), 32'(e.addr));
        check("out_data", 32'(out_data), 32'(e.data));
        check("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wr(input logic [16:0] a, input logic [15:0] d, input logic [15:0] exp);
    exp_t e;
    @(posedge pclk); #1;
    in_we = 1'b1; in_addr = a; in_data = d;
    e.addr = a; e.data = exp; e.cyc = 32'(cyc + 2);
    sb.push_back(e);
    @(posedge pclk); #1;
    in_we = 1'b0; in_addr = 17'h1ABCD; in_data = 16'h5A5A;
  endtask

  task automatic vsync_pulse(input logic [1:0] new_mode, input logic [16:0] exp_cnt,
                             input logic [1:0] old_mode);
    int pulses;
    pulses = 0;
    repeat (3) @(posedge pclk);
    #1; mode = new_mode; vsync = 1'b1;
    @(negedge pclk);
    check("mode_before_edge", 32'(active_mode), 32'(old_mode));
    check("done_before_edge", 32'(frame_done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      if (frame_done === 1'b1) pulses++;
      if (i == 0) begin
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("pixel_count", 32'(pixel_count), 32'(exp_cnt));
        check("mode_after_edge", 32'(active_mode), 32'(new_mode));
      end
    end
    check("frame_done_width", pulses, 32'd1);
    @(posedge pclk); #1; vsync = 1'b0;
    repeat (3) @(negedge pclk);
    check("no_done_on_fall", 32'(frame_done), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; vsync = 1'b0; mode = 2'd0;
    in_we = 1'b0; in_addr = 17'h0; in_data = 16'h0;

    // Reset held with activity on the write port
    for (int i = 0; i < 6; i++) begin
      @(posedge pclk); #1;
      in_we = ~in_we; in_addr = 17'(i + 1); in_data = 16'hA5A5;
      @(negedge pclk);
      check("rst_out_we", 32'(out_we), 32'd0);
    end
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_active_mode", 32'(active_mode), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_pixel_count", 32'(pixel_count), 32'd0);
    @(posedge pclk); #1; in_we = 1'b0; reset_n = 1'b1;

    wr(17'd5, 16'hF800, 16'hF800);

    // Gray
    vsync_pulse(2'd1, 17'd1, 2'd0);
    wr(17'd10, 16'hFFFF, 16'hFFFF);
    wr(17'd11, 16'h0000, 16'h0000);
    wr(17'd12, 16'hF800, 16'h4A69);

    // Invert
    vsync_pulse(2'd2, 17'd3, 2'd1);
    wr(17'd20, 16'h1234, 16'hEDCB);

    // Binary
    vsync_pulse(2'd3, 17'd1, 2'd2);
    wr(17'd30, 16'h07E0, 16'hFFFF);
    wr(17'd31, 16'h001F, 16'h0000);

    // Mid-frame mode change is deferred to the next vsync rise
    vsync_pulse(2'd0, 17'd2, 2'd3);
    wr(17'd40, 16'h1234, 16'h1234);
    mode = 2'd2;
    wr(17'd41, 16'h1234, 16'h1234);
    check("mode_held_midframe", 32'(active_mode), 32'd0);
    vsync_pulse(2'd2, 17'd2, 2'd0);
    wr(17'd42, 16'h1234, 16'hEDCB);

    // Full 320x240 frame, then an empty frame
    vsync_pulse(2'd0, 17'd1, 2'd2);
    for (int i = 0; i < 76800; i++) begin
      exp_t e;
      @(posedge pclk); #1;
      in_we = 1'b1; in_addr = 17'(i); in_data = 16'(i);
      e.addr = 17'(i); e.data = 16'(i); e.cyc = 32'(cyc + 2);
      sb.push_back(e);
    end
    @(posedge pclk); #1; in_we = 1'b0;
    vsync_pulse(2'd0, 17'd76800, 2'd0);
    vsync_pulse(2'd3, 17'd0, 2'd0);

    // Async reset while a pixel is still inside the pipeline
    wr(17'h42, 16'hBEEF, 16'hFFFF);
    repeat (3) @(posedge pclk);
    #1; in_we = 1'b1; in_addr = 17'h43; in_data = 16'h1111;
    @(posedge pclk); #1; in_we = 1'b0;
    #2; reset_n = 1'b0;
    #1;
    check("async_out_we", 32'(out_we), 32'd0);
    check("async_out_addr", 32'(out_addr), 32'd0);
    check("async_out_data", 32'(out_data), 32'd0);
    check("async_active_mode", 32'(active_mode), 32'd0);
    repeat (2) @(posedge pclk);
    #1; reset_n = 1'b1;
    repeat (5) @(posedge pclk);
    wr(17'd7, 16'hF800, 16'hF800);
    repeat (4) @(posedge pclk);
    @(negedge pclk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
